// File: rtl/onehot_select_pipe.sv
// Registered one-hot channel selector with valid/ready output stage and select error counter.
// Optional macro ONEHOT_SELECT_PRIORITY_EN: multi-bit selects are legal, lowest set index wins.
module onehot_select_pipe #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 16,
  localparam int IDXW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       hotselect,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          muxout,
  output logic [IDXW-1:0]           mux_idx,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err,
  output logic [7:0]                err_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic              accept;
  logic              consume;
  logic              legal;
  logic [IDXW-1:0]   sel_idx;
  logic [WIDTH-1:0]  sel_data;

  // Handshake: a transfer happens on an edge where valid and ready are both high.
  // in_ready depends only on the output stage, never on in_valid.
  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

`ifdef ONEHOT_SELECT_PRIORITY_EN
  assign legal = (hotselect != '0);
`else
  assign legal = (hotselect != '0) && ((hotselect & (hotselect - 1'b1)) == '0);
`endif

  // Scan downward so the lowest set bit is the one left standing.
  always_comb begin
    sel_idx  = '0;
    sel_data = data_in[WIDTH-1:0];
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (hotselect[k]) begin
        sel_idx  = k[IDXW-1:0];
        sel_data = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      muxout    <= '0;
      mux_idx   <= '0;
      sel_err   <= 1'b0;
      err_count <= 8'd0;
    end else begin
      sel_err <= 1'b0;
      case (state)
        EMPTY: begin
          if (accept && legal) begin
            state   <= FULL;
            muxout  <= sel_data;
            mux_idx <= sel_idx;
          end
        end
        FULL: begin
          if (accept && legal) begin
            muxout  <= sel_data;
            mux_idx <= sel_idx;
          end else if (consume) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
      if (accept && !legal) begin
        sel_err <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_onehot_select_pipe.sv
// Self-checking bench for onehot_select_pipe: directed scenarios plus randomized traffic vs a reference model.
module tb_onehot_select_pipe;
  localparam int W  = 32;
  localparam int CH = 16;
  localparam int IW = 4;

  logic            clk;
  logic            rst_n;
  logic [CH*W-1:0] data_in;
  logic [CH-1:0]   hotselect;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    muxout;
  logic [IW-1:0]   mux_idx;
  logic            out_valid;
  logic            out_ready;
  logic            sel_err;
  logic [7:0]      err_count;

  onehot_select_pipe #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .hotselect(hotselect),
    .in_valid(in_valid), .in_ready(in_ready), .muxout(muxout), .mux_idx(mux_idx),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] chan [CH];
  logic [W-1:0] exp_q [$];

  logic         m_valid;
  logic [W-1:0] m_data;
  logic [IW-1:0] m_idx;
  logic         m_err;
  int           m_cnt;

  function automatic bit ref_legal(input logic [CH-1:0] hot);
`ifdef ONEHOT_SELECT_PRIORITY_EN
    return $countones(hot) >= 1;
`else
    return $countones(hot) == 1;
`endif
  endfunction

  function automatic int ref_idx(input logic [CH-1:0] hot);
    for (int i = 0; i < CH; i++) if (hot[i]) return i;
    return 0;
  endfunction

  // Drive one cycle of inputs, advance the reference model across the edge, settle 1 time unit after it.
  task automatic step(input logic rst_v, input logic iv, input logic ordy, input logic [CH-1:0] hot);
    bit acc, leg, cons;
    int k;
    rst_n = rst_v; in_valid = iv; out_ready = ordy; hotselect = hot;
    for (int i = 0; i < CH; i++) data_in[i*W +: W] = chan[i];
    acc  = iv && (!m_valid || ordy);
    cons = m_valid && ordy;
    leg  = ref_legal(hot);
    k    = ref_idx(hot);
    @(posedge clk);
    if (!rst_v) begin
      m_valid = 0; m_data = '0; m_idx = '0; m_err = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      m_err = 0;
      if (cons && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc && leg) begin
        m_valid = 1; m_data = chan[k]; m_idx = k[IW-1:0];
        exp_q.push_back(chan[k]);
      end else if (cons) begin
        m_valid = 0;
      end
      if (acc && !leg) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < CH; i++) chan[i] = 32'h1000_0000 + i;
    step(0, 0, 0, '0);
    step(0, 1, 1, 16'h0001);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (muxout !== 32'h0) begin n_fail++; $display("FAIL reset_muxout: got %h want 0", muxout); end
    n_checks++; if (mux_idx !== 4'd0) begin n_fail++; $display("FAIL reset_mux_idx: got %0d want 0", mux_idx); end
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %0b want 0", sel_err); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    chan[0] = 32'h0000_0005;
    step(1, 1, 1, 16'h0001);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %0b want 1", out_valid); end
    n_checks++; if (muxout !== 32'h5) begin n_fail++; $display("FAIL basic_muxout: got %h want 5", muxout); end
    n_checks++; if (mux_idx !== 4'd0) begin n_fail++; $display("FAIL basic_mux_idx: got %0d want 0", mux_idx); end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 1, 16'h8000);
    n_checks++; if (mux_idx !== 4'd15 || muxout !== chan[15]) begin n_fail++; $display("FAIL b2b_first: got idx %0d data %h want idx 15 data %h", mux_idx, muxout, chan[15]); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready1: got %0b want 1", in_ready); end
    step(1, 1, 1, 16'h0400);
    n_checks++; if (mux_idx !== 4'd10 || muxout !== chan[10] || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got idx %0d data %h valid %0b want idx 10 data %h valid 1", mux_idx, muxout, out_valid, chan[10]); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready2: got %0b want 1", in_ready); end
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    held = muxout;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b0; #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: cycle %0d got %0b want 0", c, in_ready); end
      step(1, 1, 0, 16'h0002);
      n_checks++; if (muxout !== held || out_valid !== 1'b1 || mux_idx !== 4'd10) begin n_fail++; $display("FAIL stall_hold: cycle %0d got data %h idx %0d valid %0b want data %h idx 10 valid 1", c, muxout, mux_idx, out_valid, held); end
    end
    step(1, 1, 1, 16'h0002);
    n_checks++; if (mux_idx !== 4'd1 || muxout !== chan[1] || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_release: got idx %0d data %h valid %0b want idx 1 data %h valid 1", mux_idx, muxout, out_valid, chan[1]); end
    step(1, 0, 1, '0);
    n_checks++; if (out_valid !== 1'b0 || mux_idx !== 4'd1 || muxout !== chan[1]) begin n_fail++; $display("FAIL drain_keep: got idx %0d data %h valid %0b want idx 1 data %h valid 0", mux_idx, muxout, out_valid, chan[1]); end
  endtask

  task automatic test_illegal();
    step(0, 0, 0, '0);
    step(1, 1, 1, 16'h0000);
    n_checks++; if (sel_err !== 1'b1 || err_count !== 8'd1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_zero: got err %0b cnt %0d valid %0b want err 1 cnt 1 valid 0", sel_err, err_count, out_valid); end
    step(1, 1, 1, 16'h0003);
`ifdef ONEHOT_SELECT_PRIORITY_EN
    n_checks++; if (sel_err !== 1'b0 || err_count !== 8'd1 || out_valid !== 1'b1 || mux_idx !== 4'd0) begin n_fail++; $display("FAIL illegal_multi: got err %0b cnt %0d valid %0b idx %0d want err 0 cnt 1 valid 1 idx 0", sel_err, err_count, out_valid, mux_idx); end
`else
    n_checks++; if (sel_err !== 1'b1 || err_count !== 8'd2 || out_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_multi: got err %0b cnt %0d valid %0b want err 1 cnt 2 valid 0", sel_err, err_count, out_valid); end
`endif
    step(1, 0, 1, '0);
    n_checks++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL sel_err_pulse: got %0b want 0", sel_err); end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 300; c++) begin
      step(1, 1, 1, '0);
      if (m_cnt == 255 && c < 299) begin
        n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_reach: cycle %0d got %0d want 255", c, err_count); end
      end
    end
    n_checks++; if (err_count !== 8'd255 || sel_err !== 1'b1) begin n_fail++; $display("FAIL sat_final: got cnt %0d err %0b want cnt 255 err 1", err_count, sel_err); end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 1, 16'h0010);
    n_checks++; if (out_valid !== 1'b1 || mux_idx !== 4'd4) begin n_fail++; $display("FAIL rmid_fill: got valid %0b idx %0d want valid 1 idx 4", out_valid, mux_idx); end
    step(0, 1, 1, 16'h0004);
    n_checks++; if (out_valid !== 1'b0 || muxout !== 32'h0 || mux_idx !== 4'd0 || sel_err !== 1'b0 || err_count !== 8'd0) begin n_fail++; $display("FAIL rmid_reset: got valid %0b data %h idx %0d err %0b cnt %0d want all 0", out_valid, muxout, mux_idx, sel_err, err_count); end
    step(1, 0, 0, '0);
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_after: got valid %0b ready %0b want valid 0 ready 1", out_valid, in_ready); end
  endtask

  task automatic test_random();
    logic [CH-1:0] hot;
    logic iv, ordy;
    int r;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < CH; i++) chan[i] = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) hot = '0;
      else if (r == 1) hot = CH'($urandom);
      else hot = CH'(1) << $urandom_range(0, CH - 1);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      out_ready = ordy; #1;
      n_checks++; if (in_ready !== (!m_valid || ordy)) begin n_fail++; $display("FAIL rand_in_ready: cycle %0d got %0b want %0b", c, in_ready, (!m_valid || ordy)); end
      if (m_valid && ordy && exp_q.size() > 0) begin
        n_checks++; if (muxout !== exp_q[0]) begin n_fail++; $display("FAIL rand_consumed: cycle %0d got %h want %h", c, muxout, exp_q[0]); end
      end
      step(1, iv, ordy, hot);
      n_checks++;
      if (out_valid !== m_valid || muxout !== m_data || mux_idx !== m_idx || sel_err !== m_err || err_count !== 8'(m_cnt)) begin
        n_fail++;
        $display("FAIL rand_outputs: cycle %0d got v%0b d%h i%0d e%0b c%0d want v%0b d%h i%0d e%0b c%0d",
                 c, out_valid, muxout, mux_idx, sel_err, err_count, m_valid, m_data, m_idx, m_err, m_cnt);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; hotselect = '0; data_in = '0;
    m_valid = 0; m_data = '0; m_idx = '0; m_err = 0; m_cnt = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/onehot_select_pipe.md
# onehot_select_pipe

Parametrised, registered one-hot selector for the calculator datapath. Picks one of `CHANNELS` operation results by a one-hot select, registers it behind a valid/ready handshake, and reports the binary channel index. Flags illegal selects and keeps a saturating error count. Sits between the arithmetic/logic units and the result register/middleware readback path.

## Interface
- `WIDTH`, 32, width of each channel and of the output data.
- `CHANNELS`, 16, number of input channels; legal range 2..32.
- `IDXW`, `$clog2(CHANNELS)`, width of the index output; derived, never overridden.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `data_in`  input  CHANNELS*WIDTH  flattened channels; channel k is `data_in[k*WIDTH +: WIDTH]`.
- `hotselect`  input  CHANNELS  one-hot channel select, sampled only when `in_valid && in_ready`.
- `in_valid`  input  1  upstream offers `data_in`/`hotselect`.
- `in_ready`  output  1  block can accept this cycle.
- `muxout`  output  WIDTH  registered selected data.
- `mux_idx`  output  IDXW  binary index of the selected channel.
- `out_valid`  output  1  `muxout`/`mux_idx` hold a result.
- `out_ready`  input  1  downstream consumes the result.
- `sel_err`  output  1  one-cycle pulse: an accepted transfer had an illegal select.
- `err_count`  output  8  saturating count of illegal selects.

## Operation
- Accept: `in_valid && in_ready`. Consume: `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`, so the block sustains one transfer per cycle.
- Legal select (exactly one bit set, bit k) on accept: next cycle `muxout` = channel k, `mux_idx` = k, `out_valid` = 1.
- Illegal select (zero bits set, or more than one without the macro below) on accept: the transfer is dropped. `sel_err` pulses for one cycle and `err_count` increments, saturating at 255. On the same edge, `out_valid` clears if the old result was consumed, otherwise it and `muxout`/`mux_idx` hold.
- No accept while `out_valid && !out_ready`: `muxout`, `mux_idx` and `out_valid` hold stable.
- Consume without a new accept: `out_valid` clears and `muxout`/`mux_idx` keep their last values.
- Simultaneous consume and legal accept: the new result replaces the old one; `out_valid` stays 1.
- States: EMPTY (`out_valid` = 0) and FULL (`out_valid` = 1).
  - EMPTY -> FULL on a legal accept.
  - FULL -> EMPTY on a consume with no legal accept.
  - FULL -> FULL on a stall, or on a consume plus legal accept.
- `hotselect` bits at or above `CHANNELS` do not exist; no unreachable channel can be selected.

## Timing
- Latency: accept at edge N puts the result on the outputs after edge N; it is visible in cycle N+1.
- `in_ready` is combinational from `out_valid` and `out_ready` only, never from `in_valid`.
- `sel_err` is registered and asserts in the cycle after the offending accept.
- Reset values, applied when `rst_n` = 0 at an edge:
  - `muxout` = 0, `mux_idx` = 0, `out_valid` = 0, `sel_err` = 0, `err_count` = 0.
  - `in_ready` = 1 in the cycle after reset.
- Reset has priority over every other event.
- Reset mid-operation discards the held result and any accept in the same cycle.

## Configuration
- Macro: `ONEHOT_SELECT_PRIORITY_EN`.
- Defined: a select with more than one bit set is legal. The lowest set index wins, with no `sel_err` and no count. An all-zero select remains illegal.
- Undefined: any select that is not exactly one-hot is illegal and is handled as described under Operation.

## Test plan
- Reset, then accept `hotselect`=16'h0001 with channel 0 = 32'h0000_0005 -> next cycle `out_valid`=1, `muxout`=32'h5, `mux_idx`=0.
- Back-to-back accepts of 16'h8000 then 16'h0400 with `out_ready`=1 -> results in consecutive cycles: `mux_idx`=15 then 10, `in_ready` stays 1.
- Hold `out_ready`=0 with a result in FULL and offer 16'h0002 -> `in_ready`=0, `muxout` unchanged for 5 cycles; raising `out_ready` accepts it on that edge.
- Accept `hotselect`=0, then 16'h0003 -> two `sel_err` pulses and `err_count`=2 with the macro undefined. With the macro defined: `err_count`=1, and the second transfer yields `mux_idx`=0.
- 300 accepts of `hotselect`=0 -> `err_count` saturates at 255 and does not wrap.
- Assert `rst_n`=0 in the same cycle as an accept while FULL -> next cycle all outputs at reset values, no result from the discarded accept.
